// File: rtl/coin_acceptor.sv
// coin_acceptor: coin-slot front end. Synchronises the raw optical sensor,
// measures each pulse width in clock cycles and emits a single-cycle coin
// code (01 = 5 units, 10 = 10 units) or a reject pulse. A pulse that stays
// high for STUCK_MAX cycles raises fault until GAP consecutive lows are seen.
// Optional feature: define COIN_ACCEPTOR_TALLY_EN to build the saturating
// nickel/dime/reject tally counters; otherwise the tally outputs read zero.
module coin_acceptor #(
  parameter int unsigned CW        = 8,
  parameter int unsigned N5_MIN    = 4,
  parameter int unsigned N5_MAX    = 8,
  parameter int unsigned N10_MIN   = 12,
  parameter int unsigned N10_MAX   = 20,
  parameter int unsigned STUCK_MAX = 255,
  parameter int unsigned GAP       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sense,
  output logic [1:0]  coin,
  output logic        reject,
  output logic        fault,
  output logic        busy,
  output logic [15:0] nickel_cnt,
  output logic [15:0] dime_cnt,
  output logic [15:0] reject_cnt
);

  localparam int unsigned GW = $clog2(GAP + 2);

  localparam logic [CW-1:0] C5_MIN     = CW'(N5_MIN);
  localparam logic [CW-1:0] C5_MAX     = CW'(N5_MAX);
  localparam logic [CW-1:0] C10_MIN    = CW'(N10_MIN);
  localparam logic [CW-1:0] C10_MAX    = CW'(N10_MAX);
  localparam logic [CW-1:0] STUCK_LAST = CW'(STUCK_MAX - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP - 1);
  localparam logic [GW-1:0] ARM_LAST   = GW'(1);

  typedef enum logic [2:0] {ARM, IDLE, MEASURE, GAPWAIT, FAULT} state_t;

  state_t        state;
  logic          s1;
  logic          sense_s;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap;
  logic          in5;
  logic          in10;
  logic          done;

  // Two-flop synchroniser for the asynchronous sensor.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      sense_s <= 1'b0;
    end else begin
      s1      <= sense;
      sense_s <= s1;
    end
  end

  assign in5  = (cnt >= C5_MIN)  && (cnt <= C5_MAX);
  assign in10 = (cnt >= C10_MIN) && (cnt <= C10_MAX);
  assign done = (state == MEASURE) && !sense_s;

  // Pulse measurement / classification state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARM;
      cnt    <= '0;
      gap    <= '0;
      coin   <= '0;
      reject <= 1'b0;
      fault  <= 1'b0;
      busy   <= 1'b1;
    end else begin
      coin   <= done && in5  ? 2'b01 :
                done && in10 ? 2'b10 : 2'b00;
      reject <= done && !in5 && !in10;
      case (state)
        // Both synchroniser stages must read low on two consecutive edges:
        // the flops cleared by reset would otherwise pass for a low sensor
        // and a coin already in the beam would be measured.
        ARM: begin
          if (s1 || sense_s) begin
            gap <= '0;
          end else if (gap == ARM_LAST) begin
            gap   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap <= gap + GW'(1);
          end
        end
        IDLE: begin
          if (sense_s) begin
            cnt   <= CW'(1);
            state <= MEASURE;
            busy  <= 1'b1;
          end
        end
        MEASURE: begin
          if (sense_s) begin
            cnt <= cnt + CW'(1);
            if (cnt == STUCK_LAST) begin
              fault <= 1'b1;
              state <= FAULT;
            end
          end else begin
            gap   <= '0;
            state <= GAPWAIT;
          end
        end
        GAPWAIT, FAULT: begin
          if (sense_s) begin
            gap <= '0;
          end else if (gap == GAP_LAST) begin
            gap   <= '0;
            fault <= 1'b0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap <= gap + GW'(1);
          end
        end
        default: begin
          state <= ARM;
          busy  <= 1'b1;
        end
      endcase
    end
  end

`ifdef COIN_ACCEPTOR_TALLY_EN
  // Saturating tallies, bumped on the same edge the matching output fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      nickel_cnt <= '0;
      dime_cnt   <= '0;
      reject_cnt <= '0;
    end else begin
      if (done && in5 && (nickel_cnt != '1))
        nickel_cnt <= nickel_cnt + 16'd1;
      if (done && in10 && (dime_cnt != '1))
        dime_cnt <= dime_cnt + 16'd1;
      if (done && !in5 && !in10 && (reject_cnt != '1))
        reject_cnt <= reject_cnt + 16'd1;
    end
  end
`else
  assign nickel_cnt = '0;
  assign dime_cnt   = '0;
  assign reject_cnt = '0;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: pulses are issued as (width, following low run);
// a pulse-level model predicts each output event and its cycle, a monitor
// matches DUT events and tally values against the queued predictions.
module tb_coin_acceptor;

  localparam int unsigned CW        = 8;
  localparam int unsigned N5_MIN    = 4;
  localparam int unsigned N5_MAX    = 8;
  localparam int unsigned N10_MIN   = 12;
  localparam int unsigned N10_MAX   = 20;
  localparam int unsigned STUCK_MAX = 255;
  localparam int unsigned GAP       = 4;

  // event kinds: 1 nickel, 2 dime, 3 reject, 4 fault rise, 5 fault fall
  typedef struct {
    int t;
    int kind;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sense = 1'b1;
  logic [1:0]  coin;
  logic        reject;
  logic        fault;
  logic        busy;
  logic [15:0] nickel_cnt;
  logic [15:0] dime_cnt;
  logic [15:0] reject_cnt;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  ev_t  q[$];
  int   exp_n = 0;
  int   exp_d = 0;
  int   exp_r = 0;

  // pulse-level model state
  int   need = 0;
  int   lows_before = 100;
  bit   stuck = 1'b0;

  coin_acceptor #(
    .CW(CW), .N5_MIN(N5_MIN), .N5_MAX(N5_MAX), .N10_MIN(N10_MIN),
    .N10_MAX(N10_MAX), .STUCK_MAX(STUCK_MAX), .GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst), .sense(sense), .coin(coin), .reject(reject),
    .fault(fault), .busy(busy), .nickel_cnt(nickel_cnt),
    .dime_cnt(dime_cnt), .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int classify(int w);
    if (w >= int'(STUCK_MAX)) return 4;
    if (w >= int'(N5_MIN) && w <= int'(N5_MAX)) return 1;
    if (w >= int'(N10_MIN) && w <= int'(N10_MAX)) return 2;
    return 3;
  endfunction

  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      sense = v;
    end
  endtask

  // Issue a high pulse of w samples followed by l low samples. A pulse is
  // measured only if the preceding low run is long enough: GAP+1 lows after
  // a classified pulse (the classifying low is not a gap low), GAP lows
  // after a swallowed or stuck pulse.
  task automatic issue(input int w, input int l);
    int s;
    int k;
    @(negedge clk);
    s = cyc + 1;
    if (lows_before >= need) begin
      k = classify(w);
      if (k == 4) begin
        q.push_back('{s + int'(STUCK_MAX) + 1, 4});
        stuck = 1'b1;
        need  = GAP;
      end else begin
        q.push_back('{s + w + 2, k});
        need = GAP + 1;
      end
    end else begin
      need = GAP;
    end
    if (stuck && l >= int'(GAP)) begin
      q.push_back('{s + w - 1 + int'(GAP) + 2, 5});
      stuck = 1'b0;
    end
    lows_before = l;
    sense = 1'b1;
    drive(1'b1, w - 1);
    drive(1'b0, l);
  endtask

  // Monitor: match DUT events against the scoreboard, track tallies.
  initial begin
    bit pf;
    int kind;
    int ek;
    pf = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      kind = 0;
      if (coin == 2'b01) kind = 1;
      else if (coin == 2'b10) kind = 2;
      else if (reject) kind = 3;
      else if (fault && !pf) kind = 4;
      else if (!fault && pf) kind = 5;
      pf = fault;
      check("coin_never_11", int'(coin == 2'b11), 0);
      check("coin_reject_exclusive", int'(coin != 2'b00 && reject), 0);
      while (q.size() > 0 && q[0].t < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed_event: kind %0d due at cycle %0d not seen", q[0].kind, q[0].t);
        void'(q.pop_front());
      end
      if (rst) begin
        exp_n = 0;
        exp_d = 0;
        exp_r = 0;
      end
      if (q.size() > 0 && q[0].t == cyc) begin
        ek = q[0].kind;
        void'(q.pop_front());
        if (ek == 1) exp_n++;
        if (ek == 2) exp_d++;
        if (ek == 3) exp_r++;
        check("event_kind", kind, ek);
      end else if (kind != 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", kind, cyc);
      end
`ifdef COIN_ACCEPTOR_TALLY_EN
      check("nickel_cnt", int'(nickel_cnt), exp_n);
      check("dime_cnt", int'(dime_cnt), exp_d);
      check("reject_cnt", int'(reject_cnt), exp_r);
`else
      check("nickel_cnt", int'(nickel_cnt), 0);
      check("dime_cnt", int'(dime_cnt), 0);
      check("reject_cnt", int'(reject_cnt), 0);
`endif
    end
  end

  initial begin
    int w;
    int l;
    int r;
    // reset with a coin in the beam
    rst = 1'b1;
    sense = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_coin", int'(coin), 0);
    check("reset_reject", int'(reject), 0);
    check("reset_fault", int'(fault), 0);
    check("reset_busy", int'(busy), 1);
    check("reset_nickel_cnt", int'(nickel_cnt), 0);
    rst = 1'b0;
    drive(1'b1, 6);
    check("arm_busy_while_high", int'(busy), 1);
    drive(1'b0, 12);
    check("arm_busy_released", int'(busy), 0);
    lows_before = 100;
    need = 0;

    // directed pulses, including window and gap boundaries
    issue(6, 10);
    issue(16, 5);
    issue(4, 10);
    issue(2, 8);
    issue(10, 8);
    issue(25, 8);
    issue(300, 4);
    issue(6, 10);
    issue(6, 1);
    issue(6, 10);
    issue(6, 4);
    issue(6, 12);
    issue(254, 10);
    issue(255, 10);
    issue(8, 12);
    issue(12, 12);
    issue(20, 12);
    issue(3, 12);
    issue(21, 12);
    issue(1, 12);

    // randomized pulses and gaps
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: w = $urandom_range(N5_MIN, N5_MAX);
        3, 4, 5: w = $urandom_range(N10_MIN, N10_MAX);
        6:       w = $urandom_range(1, N5_MIN - 1);
        7:       w = $urandom_range(N5_MAX + 1, N10_MIN - 1);
        default: w = $urandom_range(N10_MAX + 1, N10_MAX + 10);
      endcase
      l = $urandom_range(1, 12);
      issue(w, l);
    end
    drive(1'b0, 30);
    check("idle_busy", int'(busy), 0);
    check("queue_drained", q.size(), 0);

    // reset in the middle of a dime-length pulse
    @(negedge clk);
    sense = 1'b1;
    drive(1'b1, 5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 9);
    check("midreset_busy", int'(busy), 1);
    drive(1'b0, 20);
    check("midreset_busy_released", int'(busy), 0);
    check("midreset_nickel_cnt", int'(nickel_cnt), 0);
    check("midreset_dime_cnt", int'(dime_cnt), 0);
    check("midreset_reject_cnt", int'(reject_cnt), 0);
    lows_before = 100;
    need = 0;
    issue(6, 10);
    drive(1'b0, 10);
    check("final_queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
